// File: rtl/tpu_mac_responder.sv
// Matrix-unit responder: holds A/B/C and computes C += A*B with one MAC per cycle.
// Latency is DIM^3 cycles from start to done. Writes are accepted only in IDLE; start is held by execute until done.
module tpu_mac_responder #(
    parameter int DIM     = 32,
    parameter int IDX_W   = 5,
    parameter int BITS_AB = 16,
    parameter int BITS_C  = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              wr_en_a_i,
    input  logic              wr_en_b_i,
    input  logic              wr_en_c_i,
    input  logic [IDX_W-1:0]  row_i,
    input  logic [IDX_W-1:0]  col_i,
    input  logic [BITS_C-1:0] data_i,
    output logic [BITS_C-1:0] data_o,
    output logic              done_o,
    output logic              busy_o
);

    localparam int AW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [AW-1:0] LAST = AW'(DIM - 1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     i_q, i_d, j_q, j_d, k_q, k_d;
    logic [BITS_C-1:0] acc_q, acc_d;

    logic signed [BITS_AB-1:0] a_mem [DIM][DIM];
    logic signed [BITS_AB-1:0] b_mem [DIM][DIM];
    logic        [BITS_C-1:0]  c_mem [DIM][DIM];

    logic                        idx_ok, wr_ok, mac_last, c_wb;
    logic [AW-1:0]               row_a, col_a;
    logic signed [BITS_AB-1:0]   a_el, b_el;
    logic signed [2*BITS_AB-1:0] prod;
    logic [BITS_C-1:0]           prod_c, addend;

    // Out-of-range indices must neither alias onto a real element nor read one.
    assign idx_ok = ({1'b0, row_i} < (IDX_W + 1)'(DIM)) && ({1'b0, col_i} < (IDX_W + 1)'(DIM));
    assign row_a  = row_i[AW-1:0];
    assign col_a  = col_i[AW-1:0];
    assign wr_ok  = (state_q == S_IDLE) && idx_ok;

    assign a_el     = a_mem[i_q][k_q];
    assign b_el     = b_mem[k_q][j_q];
    assign prod     = (2*BITS_AB)'(a_el) * (2*BITS_AB)'(b_el);
    assign prod_c   = BITS_C'(prod);
    assign addend   = (k_q == '0) ? c_mem[i_q][j_q] : acc_q;
    assign mac_last = (i_q == LAST) && (j_q == LAST) && (k_q == LAST);
    assign c_wb     = (state_q == S_MAC) && (k_q == LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_MAC;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            S_MAC: begin
                acc_d = addend + prod_c;
                if (k_q == LAST) begin
                    k_d = '0;
                    if (j_q == LAST) begin
                        j_d = '0;
                        i_d = i_q + 1'b1;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
                if (mac_last) begin
                    state_d = S_DONE;
                    i_d     = '0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Storage is deliberately unreset; C write-back and host writes never coincide.
    always_ff @(posedge clk_i) begin
        if (wr_ok && wr_en_a_i) a_mem[row_a][col_a] <= data_i[BITS_AB-1:0];
        if (wr_ok && wr_en_b_i) b_mem[row_a][col_a] <= data_i[BITS_AB-1:0];
        if (c_wb)
            c_mem[i_q][j_q] <= acc_d;
        else if (wr_ok && wr_en_c_i)
            c_mem[row_a][col_a] <= data_i;
    end

    always_comb begin
        done_o = (state_q == S_DONE);
        busy_o = (state_q != S_IDLE);
        data_o = idx_ok ? c_mem[row_a][col_a] : '0;
    end

endmodule
